// File: rtl/match_pkg.sv
// Shared state encoding and default game parameters for the tug-of-war match scheduler.
package match_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PULL      = 3'd1,
    CHECK     = 3'd2,
    SPEED_REQ = 3'd3,
    SPEED_RUN = 3'd4,
    OVER      = 3'd5
  } state_t;

  localparam int unsigned WIN_SCORE_DEF     = 3;
  localparam int unsigned SPEED_EVERY_DEF   = 2;
  localparam int unsigned SW_DEF            = 4;
  localparam int unsigned SPEED_TIMEOUT_DEF = 16;

endpackage

// File: rtl/score_counter.sv
// One player's score: register with synchronous clear and increment.
module score_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/match_scheduler.sv
// Round sequencer for the tug-of-war game: pull rounds, periodic speed rounds, scoring, winner.
// Optional macro SPEED_TIMEOUT_EN aborts a speed round after SPEED_TIMEOUT slow ticks.
module match_scheduler
  import match_pkg::*;
#(
  parameter int unsigned WIN_SCORE     = WIN_SCORE_DEF,
  parameter int unsigned SPEED_EVERY   = SPEED_EVERY_DEF,
  parameter int unsigned SW            = SW_DEF,
  parameter int unsigned SPEED_TIMEOUT = SPEED_TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          slowen1024,
  input  logic          start,
  input  logic          pull_done,
  input  logic          pull_right,
  input  logic          winspeed,
  input  logic          speed_right,
  input  logic          speed_tie,
  input  logic          speed_exit,
  output logic          pull_round,
  output logic          speed_round,
  output logic [SW-1:0] score_left,
  output logic [SW-1:0] score_right,
  output logic          match_over,
  output logic          winner_right,
  output logic          speed_timeout
);

  localparam int unsigned PCW = (SPEED_EVERY > 1) ? $clog2(SPEED_EVERY + 1) : 1;
  localparam int unsigned TW  = SW + 1;

  state_t         state;
  state_t         state_next;
  logic [PCW-1:0] pull_cnt;
  logic           scored;
  logic           timeout_hit;
  logic           clr_scores;
  logic           inc_left;
  logic           inc_right;
  logic           pull_cnt_clr;
  logic           pull_cnt_inc;
  logic           pull_round_d;
  logic           speed_round_d;
  logic           match_over_d;
  logic           winner_right_d;
  logic           speed_timeout_d;

`ifdef SPEED_TIMEOUT_EN
  logic [TW-1:0] tick_cnt;

  // Slow-tick count for the current speed round; saturates at the limit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
    end else if (state != SPEED_RUN) begin
      tick_cnt <= '0;
    end else if (slowen1024 && (tick_cnt != TW'(SPEED_TIMEOUT))) begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  assign timeout_hit = (state == SPEED_RUN) && (tick_cnt == TW'(SPEED_TIMEOUT)) && !speed_exit;
`else
  logic unused_timeout;
  assign unused_timeout = slowen1024 | (TW'(SPEED_TIMEOUT) == '0);
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next      = state;
    clr_scores      = 1'b0;
    inc_left        = 1'b0;
    inc_right       = 1'b0;
    pull_cnt_clr    = 1'b0;
    pull_cnt_inc    = 1'b0;
    speed_timeout_d = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          clr_scores   = 1'b1;
          pull_cnt_clr = 1'b1;
          state_next   = PULL;
        end
      end
      PULL: begin
        if (pull_done) begin
          inc_right    = pull_right;
          inc_left     = !pull_right;
          pull_cnt_inc = 1'b1;
          state_next   = CHECK;
        end
      end
      CHECK: begin
        if ((score_left == SW'(WIN_SCORE)) || (score_right == SW'(WIN_SCORE))) begin
          state_next = OVER;
        end else if (pull_cnt == PCW'(SPEED_EVERY)) begin
          pull_cnt_clr = 1'b1;
          state_next   = SPEED_REQ;
        end else begin
          state_next = PULL;
        end
      end
      SPEED_REQ: begin
        state_next = SPEED_RUN;
      end
      SPEED_RUN: begin
        // Only the first result of a round scores; a tie scores nobody.
        if (winspeed && !scored && !timeout_hit && !speed_tie) begin
          inc_right = speed_right;
          inc_left  = !speed_right;
        end
        if (speed_exit) begin
          state_next = CHECK;
        end else if (timeout_hit) begin
          state_next      = CHECK;
          speed_timeout_d = 1'b1;
        end
      end
      OVER: begin
        if (start) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Scores are stable in CHECK, so the winner is known on entry to OVER.
    pull_round_d   = (state_next == PULL);
    speed_round_d  = (state_next == SPEED_REQ);
    match_over_d   = (state_next == OVER);
    winner_right_d = (state_next == OVER) && (score_right == SW'(WIN_SCORE));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pull_cnt      <= '0;
      scored        <= 1'b0;
      pull_round    <= 1'b0;
      speed_round   <= 1'b0;
      match_over    <= 1'b0;
      winner_right  <= 1'b0;
      speed_timeout <= 1'b0;
    end else begin
      if (pull_cnt_clr) begin
        pull_cnt <= '0;
      end else if (pull_cnt_inc) begin
        pull_cnt <= pull_cnt + PCW'(1);
      end
      scored        <= (state == SPEED_RUN) && (scored || winspeed);
      pull_round    <= pull_round_d;
      speed_round   <= speed_round_d;
      match_over    <= match_over_d;
      winner_right  <= winner_right_d;
      speed_timeout <= speed_timeout_d;
    end
  end

  score_counter #(.W(SW)) u_score_left (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_scores),
    .inc   (inc_left),
    .count (score_left)
  );

  score_counter #(.W(SW)) u_score_right (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_scores),
    .inc   (inc_right),
    .count (score_right)
  );

endmodule

// File: tb/tb_match_scheduler.sv
// Self-checking bench for match_scheduler: directed scenarios plus randomized play vs a game-level model.
module tb_match_scheduler;

  localparam int unsigned WIN   = 3;
  localparam int unsigned EVERY = 2;
  localparam int unsigned SW    = 4;
  localparam int unsigned TO    = 16;
`ifdef SPEED_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam logic [2:0] MD_IDLE   = 3'd0;
  localparam logic [2:0] MD_PULL   = 3'd1;
  localparam logic [2:0] MD_DECIDE = 3'd2;
  localparam logic [2:0] MD_REQ    = 3'd3;
  localparam logic [2:0] MD_SPEED  = 3'd4;
  localparam logic [2:0] MD_OVER   = 3'd5;

  typedef struct packed {
    logic [2:0] mode;
    logic [7:0] left;
    logic [7:0] right;
    logic [7:0] pulls;
    logic       scored;
    logic [7:0] ticks;
    logic       to_pulse;
  } model_t;

  logic clk = 1'b0, rst = 1'b1, slowen1024 = 1'b0, start = 1'b0;
  logic pull_done = 1'b0, pull_right = 1'b0, winspeed = 1'b0;
  logic speed_right = 1'b0, speed_tie = 1'b0, speed_exit = 1'b0;
  logic pull_round, speed_round, match_over, winner_right, speed_timeout;
  logic [SW-1:0] score_left, score_right;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;
  model_t m;

  always #5 clk = ~clk;

  match_scheduler #(
    .WIN_SCORE(WIN), .SPEED_EVERY(EVERY), .SW(SW), .SPEED_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .slowen1024(slowen1024), .start(start),
    .pull_done(pull_done), .pull_right(pull_right), .winspeed(winspeed),
    .speed_right(speed_right), .speed_tie(speed_tie), .speed_exit(speed_exit),
    .pull_round(pull_round), .speed_round(speed_round),
    .score_left(score_left), .score_right(score_right),
    .match_over(match_over), .winner_right(winner_right),
    .speed_timeout(speed_timeout)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Game-level reference: what the match looks like after this clock edge.
  function automatic model_t model_next(input model_t cur);
    model_t n;
    logic   tmo;
    n = cur;
    n.to_pulse = 1'b0;
    tmo = 1'b0;
    case (cur.mode)
      MD_IDLE: if (start) begin
        n.left = 8'd0; n.right = 8'd0; n.pulls = 8'd0; n.mode = MD_PULL;
      end
      MD_PULL: if (pull_done) begin
        if (pull_right) n.right = cur.right + 8'd1;
        else            n.left  = cur.left + 8'd1;
        n.pulls = cur.pulls + 8'd1;
        n.mode  = MD_DECIDE;
      end
      MD_DECIDE: begin
        if (cur.left == WIN || cur.right == WIN) n.mode = MD_OVER;
        else if (cur.pulls == EVERY) begin n.pulls = 8'd0; n.mode = MD_REQ; end
        else n.mode = MD_PULL;
      end
      MD_REQ: begin
        n.mode = MD_SPEED; n.scored = 1'b0; n.ticks = 8'd0;
      end
      MD_SPEED: begin
        tmo = TO_EN && (cur.ticks == TO) && !speed_exit;
        if (winspeed && !cur.scored && !tmo && !speed_tie) begin
          if (speed_right) n.right = cur.right + 8'd1;
          else             n.left  = cur.left + 8'd1;
        end
        if (winspeed) n.scored = 1'b1;
        if (slowen1024 && cur.ticks < TO) n.ticks = cur.ticks + 8'd1;
        if (speed_exit) n.mode = MD_DECIDE;
        else if (tmo) begin n.mode = MD_DECIDE; n.to_pulse = 1'b1; end
      end
      MD_OVER: if (start) n.mode = MD_IDLE;
      default: n.mode = MD_IDLE;
    endcase
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) m <= '0;
    else      m <= model_next(m);
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_pull_round",    pull_round,    m.mode == MD_PULL);
      chk("m_speed_round",   speed_round,   m.mode == MD_REQ);
      chk("m_match_over",    match_over,    m.mode == MD_OVER);
      chk("m_winner_right",  winner_right,  (m.mode == MD_OVER) && (m.right == WIN));
      chk("m_speed_timeout", speed_timeout, m.to_pulse);
      chk("m_score_left",    score_left,    m.left);
      chk("m_score_right",   score_right,   m.right);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_pull(input logic r);
    pull_done = 1'b1; pull_right = r;
    tick();
    pull_done = 1'b0; pull_right = 1'b0;
    tick();
  endtask

  task automatic fresh_match();
    rst = 1'b0; tick(); rst = 1'b1; tick();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  int seen;

  initial begin
    #2 rst = 1'b0;
    cmp_en = 1'b1;
    #1;
    chk("rst_pull_round", pull_round, 0);
    chk("rst_match_over", match_over, 0);
    chk("rst_scores", {score_left, score_right}, 0);
    tick(); tick(); rst = 1'b1; tick();
    chk("idle_no_pull", pull_round, 0);

    // Split pulls, then a speed request two cycles after the second pull.
    start = 1'b1; tick(); start = 1'b0;
    chk("a_pull_on", pull_round, 1);
    pull_done = 1'b1; pull_right = 1'b1; tick(); pull_done = 1'b0; pull_right = 1'b0;
    chk("a_right1", score_right, 1);
    chk("a_pull_gap", pull_round, 0);
    tick();
    chk("a_pull_latency", pull_round, 1);
    pull_done = 1'b1; tick(); pull_done = 1'b0;
    chk("a_left1", score_left, 1);
    chk("a_no_req_yet", speed_round, 0);
    tick();
    chk("a_speed_req", speed_round, 1);
    tick();
    chk("a_speed_req_1cyc", speed_round, 0);

    // Tie wins over right; no score change.
    winspeed = 1'b1; speed_tie = 1'b1; speed_right = 1'b1; tick();
    winspeed = 1'b0; speed_tie = 1'b0; speed_right = 1'b0;
    chk("b_tie_scores", {score_left, score_right}, {4'd1, 4'd1});
    speed_exit = 1'b1; tick(); speed_exit = 1'b0;
    chk("b_check_gap", pull_round, 0);
    tick();
    chk("b_pull_back", pull_round, 1);

    // Asynchronous reset mid-pull with left at 2.
    do_pull(1'b0);
    chk("r_left2", score_left, 2);
    rst = 1'b0;
    #1;
    chk("r_pull_off", pull_round, 0);
    chk("r_scores0", {score_left, score_right}, 0);
    tick(); tick(); rst = 1'b1; tick(); tick();
    chk("r_stay_idle", pull_round, 0);

    // Right sweeps: two pulls then the speed round.
    start = 1'b1; tick(); start = 1'b0;
    do_pull(1'b1);
    do_pull(1'b1);
    chk("w_speed_req", speed_round, 1);
    tick();
    winspeed = 1'b1; speed_right = 1'b1; tick(); winspeed = 1'b0; speed_right = 1'b0;
    chk("w_right3", score_right, 3);
    speed_exit = 1'b1; tick(); speed_exit = 1'b0; tick();
    chk("w_over", match_over, 1);
    chk("w_winner_right", winner_right, 1);
    seen = 0;
    repeat (8) begin tick(); seen += int'(speed_round); end
    chk("w_no_more_speed", seen, 0);
    start = 1'b1; tick(); start = 1'b0;
    chk("w_back_idle", match_over, 0);

    // Result and exit in the same cycle.
    start = 1'b1; tick(); start = 1'b0;
    do_pull(1'b0);
    do_pull(1'b1);
    tick();
    winspeed = 1'b1; speed_right = 1'b1; speed_exit = 1'b1; tick();
    winspeed = 1'b0; speed_right = 1'b0; speed_exit = 1'b0;
    chk("s_right2", score_right, 2);
    chk("s_in_check", pull_round, 0);
    tick();
    chk("s_pull_again", pull_round, 1);

    // Second result in one speed round is ignored.
    fresh_match();
    do_pull(1'b1);
    do_pull(1'b0);
    tick();
    winspeed = 1'b1; tick(); winspeed = 1'b0;
    chk("d_left2", score_left, 2);
    winspeed = 1'b1; speed_right = 1'b1; tick(); winspeed = 1'b0; speed_right = 1'b0;
    tick();
    chk("d_second_ignored", score_right, 1);
    speed_exit = 1'b1; tick(); speed_exit = 1'b0; tick();
    chk("d_pull_back", pull_round, 1);

    // Speed round starved of an exit.
    fresh_match();
    do_pull(1'b1);
    do_pull(1'b0);
    tick();
`ifdef SPEED_TIMEOUT_EN
    slowen1024 = 1'b1;
    repeat (TO) tick();
    slowen1024 = 1'b0;
    chk("t_not_yet", speed_timeout, 0);
    tick();
    chk("t_timeout", speed_timeout, 1);
    chk("t_scores", {score_left, score_right}, {4'd1, 4'd1});
    tick();
    chk("t_pulse_1cyc", speed_timeout, 0);
    chk("t_pull_back", pull_round, 1);
`else
    seen = 0;
    repeat (100) begin
      slowen1024 = 1'b1; tick(); slowen1024 = 1'b0;
      seen += int'(speed_timeout) + int'(pull_round);
      tick();
      seen += int'(speed_timeout) + int'(pull_round);
    end
    chk("t_still_waiting", seen, 0);
    speed_exit = 1'b1; tick(); speed_exit = 1'b0; tick();
    chk("t_exit_pull", pull_round, 1);
`endif

    // Randomized play against the model.
    repeat (3000) begin
      rst         = ($urandom_range(0, 299) != 0);
      start       = ($urandom_range(0, 19) == 0);
      pull_done   = ($urandom_range(0, 3) == 0);
      pull_right  = 1'($urandom_range(0, 1));
      winspeed    = ($urandom_range(0, 5) == 0);
      speed_right = 1'($urandom_range(0, 1));
      speed_tie   = ($urandom_range(0, 3) == 0);
      speed_exit  = ($urandom_range(0, 7) == 0);
      slowen1024  = 1'($urandom_range(0, 1));
      tick();
    end
    rst = 1'b1; start = 1'b0; pull_done = 1'b0; winspeed = 1'b0;
    speed_exit = 1'b0; slowen1024 = 1'b0;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/match_scheduler.md
Name: match_scheduler

Overview:
- Top-level round sequencer for the tug-of-war game.
- Alternates normal pull rounds with speed rounds and keeps the left/right score.
- Drives `pull_round` to the pull-round datapath and `speed_round` to the speed-round controller.
- Consumes their completion handshakes (`pull_done`, `winspeed`, `speed_exit`) and declares the match winner.

Parameters:
- WIN_SCORE, 3, points needed to win the match (1..15).
- SPEED_EVERY, 2, number of pull rounds played before each speed round (>=1).
- SW, 4, score/counter width; must satisfy 2^SW > WIN_SCORE.
- SPEED_TIMEOUT, 16, slowen1024 ticks allowed in a speed round (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- slowen1024  in  1  one-cycle slow tick.
- start  in  1  debounced one-cycle start/restart pulse.
- pull_done  in  1  one-cycle pulse: pull round finished.
- pull_right  in  1  valid with pull_done; 1 = right won the pull.
- winspeed  in  1  one-cycle pulse: speed-round result valid.
- speed_right  in  1  valid with winspeed; right won.
- speed_tie  in  1  valid with winspeed; tie.
- speed_exit  in  1  speed round fully complete, including the winner display.
- pull_round  out  1  level; enables the pull-round datapath.
- speed_round  out  1  one-cycle request that starts a speed round.
- score_left  out  SW  left score.
- score_right  out  SW  right score.
- match_over  out  1  level; match finished.
- winner_right  out  1  valid while match_over; 1 = right won.
- speed_timeout  out  1  one-cycle pulse (see Optional Feature).

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; all outputs 0; scores 0; pull counter 0.
  - Reset mid-round aborts immediately; no score update occurs.
- All outputs are registered or decoded from state only. No input-to-output combinational path.
- States and transitions:
  - IDLE: outputs 0. On start: clear scores and pull counter, go to PULL.
  - PULL: pull_round=1. On pull_done: increment the winner's score (pull_right selects the side), increment pull counter, go to CHECK. start is ignored.
  - CHECK: single cycle, outputs 0.
    - Either score == WIN_SCORE -> OVER.
    - Else pull counter == SPEED_EVERY -> clear pull counter, go to SPEED_REQ.
    - Else -> PULL.
  - SPEED_REQ: speed_round=1 for exactly one cycle, then SPEED_RUN.
  - SPEED_RUN: outputs 0.
    - On winspeed: speed_tie=1 -> no score change; else speed_right=1 -> score_right+1; else score_left+1. speed_tie takes priority over speed_right.
    - Only the first winspeed in a round scores; later pulses are ignored.
    - On speed_exit -> CHECK.
    - winspeed and speed_exit in the same cycle: the score updates and the state goes to CHECK in that same cycle.
    - speed_exit without a prior winspeed: no score change.
  - OVER: match_over=1; winner_right = (score_right == WIN_SCORE); scores hold. On start -> IDLE.
  - Unused encodings -> IDLE.
- Scores never exceed WIN_SCORE because CHECK stops play first. Arithmetic is unsigned SW-bit with no wrap possible.
- pull_done outside PULL and winspeed outside SPEED_RUN are ignored.
- Latency:
  - pull_done to next pull_round high: 2 cycles.
  - pull_done to speed_round pulse: 2 cycles.

Optional Feature:
- Macro: SPEED_TIMEOUT_EN.
- With the macro:
  - An SW+1-bit tick counter clears on entering SPEED_RUN and increments on each slowen1024 while in SPEED_RUN.
  - When the counter reaches SPEED_TIMEOUT without speed_exit: pulse speed_timeout for one cycle, go to CHECK with no score change.
  - speed_exit in the same cycle as the timeout takes priority; speed_timeout stays 0.
- Without the macro: speed_timeout is tied to 0 and SPEED_RUN waits indefinitely.

Decomposition:
- Package match_pkg holds:
  - state encodings (IDLE, PULL, CHECK, SPEED_REQ, SPEED_RUN, OVER);
  - WIN_SCORE and SPEED_EVERY defaults.
- One natural sub-module: score_counter.
  - SW-bit register with synchronous clear and increment, async active-low reset.
  - Instantiated twice, once for left and once for right.

Test Plan:
- Reset held low mid-PULL with score_left=2 -> all outputs 0, scores 0, state IDLE immediately; pull_round stays 0 until the next start.
- start, then pull_done with pull_right=1, then pull_done with pull_right=0 -> scores 1/1; speed_round pulses once, exactly 2 cycles after the second pull_done.
- In SPEED_RUN: winspeed with speed_tie=1 and speed_right=1, then speed_exit -> scores unchanged at 1/1; pull_round rises 2 cycles after speed_exit.
- Right wins pulls 1 and 2, then the speed round -> score_right=3 after the speed round; CHECK leads to OVER; match_over=1, winner_right=1, and no further speed_round pulses.
- winspeed (right) and speed_exit in the same cycle -> score_right increments by 1 and the state reaches CHECK on the next edge; a second winspeed pulse before speed_exit is not counted.
- With SPEED_TIMEOUT_EN and SPEED_TIMEOUT=16: 16 slowen1024 ticks without speed_exit -> one-cycle speed_timeout, scores unchanged, play returns to PULL; without the macro, 100 ticks -> state remains SPEED_RUN and speed_timeout=0.
